// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record layout, beat order and header fields.
// No logic here; the beat serialiser helper is purely combinational.
package trace_pkg;

    localparam int TRACE_XLEN   = 32;
    localparam int TRACE_BEATS  = 5;
    localparam int HDR_DROP_BIT = 31;
    localparam int HDR_RD_LSB   = 0;
    localparam int HDR_RD_W     = 5;

    typedef struct packed {
        logic [31:0]           cycle;
        logic [TRACE_XLEN-1:0] tag;
        logic [31:0]           instr;
        logic                  drop_flag;
        logic [4:0]            rd_addr;
        logic [TRACE_XLEN-1:0] data;
    } trace_rec_t;

    typedef enum logic [2:0] {
        BEAT_CYCLE,
        BEAT_TAG,
        BEAT_INSTR,
        BEAT_HDR,
        BEAT_DATA
    } beat_e;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    function automatic logic [31:0] beat_payload(input trace_rec_t rec, input beat_e beat);
        logic [31:0] p;
        p = '0;
        case (beat)
            BEAT_CYCLE: p = rec.cycle;
            BEAT_TAG:   p = rec.tag;
            BEAT_INSTR: p = rec.instr;
            BEAT_HDR: begin
                p[HDR_DROP_BIT]             = rec.drop_flag;
                p[HDR_RD_LSB +: HDR_RD_W]   = rec.rd_addr;
            end
            BEAT_DATA:  p = rec.data;
            default:    p = '0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record store; level/full/empty registered, head read combinationally from rd_ptr.
// No internal backpressure: caller gates push on !full|pop; push+pop when full overwrites the popped slot.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  trace_rec_t    push_rec,
    input  logic          pop,
    output trace_rec_t    head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_nxt;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_rec;
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/commit_trace_buf.sv
// Captures writebacks as trace records and serialises each as 5 x 32-bit beats; rd_valid 1 cycle after push edge.
// rd_ready low holds the current beat; a full buffer drops new records and counts them unless a pop frees a slot.
module commit_trace_buf
    import trace_pkg::*;
#(
    parameter int  XLEN   = 32,
    parameter int  DEPTH  = 16,
    parameter int  DROP_W = 16,
    localparam int LW     = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trace_en,
    input  logic              clear,
    input  logic              wb_en,
    input  logic [XLEN-1:0]   wb_tag,
    input  logic [31:0]       wb_instr,
    input  logic [4:0]        wb_rd_addr,
    input  logic [XLEN-1:0]   wb_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [31:0]       rd_data,
    output logic              rd_last,
    output logic [LW-1:0]     level,
    output logic [DROP_W-1:0] drop_count,
    output logic              full,
    output logic              empty
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("commit_trace_buf: only XLEN=32 is supported");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("commit_trace_buf: DEPTH must be a power of two >= 2");
    end

    logic [31:0] cycle_cnt;
    logic        pending_drop;
    state_e      state, state_nxt;
    beat_e       beat, beat_nxt;
    trace_rec_t  wr_rec;
    trace_rec_t  head;
    logic        capture, accept, push, pop, drop;

    assign capture = wb_en & trace_en & ~clear;
    assign accept  = rd_valid & rd_ready;
    assign pop     = accept & (beat == BEAT_DATA) & ~clear;
    assign push    = capture & (~full | pop);
    assign drop    = capture & full & ~pop;

    assign wr_rec = '{cycle:     cycle_cnt,
                      tag:       wb_tag,
                      instr:     wb_instr,
                      drop_flag: pending_drop,
                      rd_addr:   wb_rd_addr,
                      data:      wb_data};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .push     (push),
        .push_rec (wr_rec),
        .pop      (pop),
        .head     (head),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    // Free-running timestamp; deliberately untouched by clear so traces stay comparable across flushes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            drop_count   <= '0;
            pending_drop <= 1'b0;
        end else if (drop) begin
            pending_drop <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + 1'b1;
            end
        end else if (push) begin
            pending_drop <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            beat  <= BEAT_CYCLE;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
        end
    end

    // A same-cycle push keeps the stream going even when the popped record was the last one.
    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        if (clear) begin
            state_nxt = ST_IDLE;
            beat_nxt  = BEAT_CYCLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        state_nxt = ST_SEND;
                        beat_nxt  = BEAT_CYCLE;
                    end
                end
                ST_SEND: begin
                    if (accept) begin
                        if (beat == BEAT_DATA) begin
                            beat_nxt = BEAT_CYCLE;
                            if (level == LW'(1) && !push) begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            beat_nxt = beat_e'(beat + 3'd1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    beat_nxt  = BEAT_CYCLE;
                end
            endcase
        end
    end

    assign rd_valid = (state == ST_SEND);
    assign rd_last  = rd_valid & (beat == BEAT_DATA);
    assign rd_data  = rd_valid ? beat_payload(head, beat) : 32'h0;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed bench for commit_trace_buf at DEPTH=4: single record, backpressure, overflow,
// full push+pop, clear mid-record, reset mid-record and trace_en gating.
module tb_commit_trace_buf;

    localparam int DEPTH  = 4;
    localparam int LW     = $clog2(DEPTH) + 1;
    localparam int DROP_W = 16;

    typedef logic [4:0][31:0] rec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              trace_en;
    logic              clear;
    logic              wb_en;
    logic [31:0]       wb_tag;
    logic [31:0]       wb_instr;
    logic [4:0]        wb_rd_addr;
    logic [31:0]       wb_data;
    logic              rd_valid;
    logic              rd_ready;
    logic [31:0]       rd_data;
    logic              rd_last;
    logic [LW-1:0]     level;
    logic [DROP_W-1:0] drop_count;
    logic              full;
    logic              empty;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] cyc;

    always #5 clk = ~clk;

    commit_trace_buf #(.XLEN(32), .DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trace_en   (trace_en),
        .clear      (clear),
        .wb_en      (wb_en),
        .wb_tag     (wb_tag),
        .wb_instr   (wb_instr),
        .wb_rd_addr (wb_rd_addr),
        .wb_data    (wb_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .level      (level),
        .drop_count (drop_count),
        .full       (full),
        .empty      (empty)
    );

    // Reference timestamp: counts cycles with rst_n high, restarts on reset.
    always @(posedge clk) begin
        if (!rst_n) cyc <= '0;
        else        cyc <= cyc + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input logic [31:0] c, input logic [31:0] t, input logic [31:0] i,
                                input logic d, input logic [4:0] rd, input logic [31:0] dat);
        rec_t r;
        r[0] = c;
        r[1] = t;
        r[2] = i;
        r[3] = {d, 26'b0, rd};
        r[4] = dat;
        return r;
    endfunction

    task automatic wb(input logic [31:0] t, input logic [31:0] i, input logic [4:0] rd,
                      input logic [31:0] d);
        wb_en      = 1'b1;
        wb_tag     = t;
        wb_instr   = i;
        wb_rd_addr = rd;
        wb_data    = d;
        step();
        wb_en      = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!rd_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, " valid_timeout"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic recv(input string tag, input rec_t r);
        rd_ready = 1'b1;
        wait_valid(tag);
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("%s valid%0d", tag, b), 32'(rd_valid), 32'd1);
            chk($sformatf("%s beat%0d", tag, b), rd_data, r[b]);
            chk($sformatf("%s last%0d", tag, b), 32'(rd_last), 32'(b == 4));
            step();
        end
    endtask

    rec_t        r1, ra, rb, r7, f4, nr, z;
    rec_t        ov [6];
    rec_t        f  [4];
    rec_t        c  [5];
    rec_t        t  [4];
    int          k, n;
    logic        hold_pend;
    logic [31:0] held;

    initial begin
        rst_n = 1'b0; trace_en = 1'b1; clear = 1'b0; wb_en = 1'b0; rd_ready = 1'b0;
        wb_tag = '0; wb_instr = '0; wb_rd_addr = '0; wb_data = '0;
        step();
        step();
        chk("rst level", 32'(level), 32'd0);
        chk("rst empty", 32'(empty), 32'd1);
        chk("rst full", 32'(full), 32'd0);
        chk("rst drop", 32'(drop_count), 32'd0);
        chk("rst valid", 32'(rd_valid), 32'd0);
        chk("rst last", 32'(rd_last), 32'd0);
        chk("rst data", rd_data, 32'd0);

        // Single record captured at timestamp 7.
        rst_n = 1'b1;
        repeat (7) step();
        rd_ready = 1'b1;
        r1 = mk(32'd7, 32'h0000_0100, 32'h0050_0093, 1'b0, 5'd1, 32'h5);
        wb(32'h0000_0100, 32'h0050_0093, 5'd1, 32'h5);
        chk("single level", 32'(level), 32'd1);
        chk("single empty0", 32'(empty), 32'd0);
        recv("single", r1);
        chk("single empty1", 32'(empty), 32'd1);
        chk("single idle", 32'(rd_valid), 32'd0);

        // Two records, reader alternating ready: beats held, no bubble.
        rd_ready = 1'b0;
        ra = mk(cyc, 32'hA000_0004, 32'h1111_1111, 1'b0, 5'd3, 32'hCAFE_0001);
        wb(32'hA000_0004, 32'h1111_1111, 5'd3, 32'hCAFE_0001);
        rb = mk(cyc, 32'hA000_0008, 32'h2222_2222, 1'b0, 5'd31, 32'hCAFE_0002);
        wb(32'hA000_0008, 32'h2222_2222, 5'd31, 32'hCAFE_0002);
        wait_valid("bp");
        rd_ready = 1'b1;
        k = 0; n = 0; hold_pend = 1'b0; held = '0;
        while (k < 10 && n < 40) begin
            chk($sformatf("bp valid k%0d", k), 32'(rd_valid), 32'd1);
            if (hold_pend) chk($sformatf("bp hold k%0d", k), rd_data, held);
            if (rd_ready) begin
                chk($sformatf("bp beat%0d", k), rd_data, (k < 5) ? ra[k] : rb[k-5]);
                chk($sformatf("bp last%0d", k), 32'(rd_last), 32'((k % 5) == 4));
                k++;
                hold_pend = 1'b0;
            end else begin
                hold_pend = 1'b1;
                held      = rd_data;
            end
            step();
            rd_ready = ~rd_ready;
            n++;
        end
        chk("bp beats", k, 32'd10);
        chk("bp empty", 32'(empty), 32'd1);

        // Overflow: six writebacks into four slots with the reader stalled.
        rd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ov[i] = mk(cyc, 32'h200 + i, 32'h0000_0013 + (i << 8), 1'b0, 5'(i + 2), 32'hA0 + i);
            wb(32'h200 + i, 32'h0000_0013 + (i << 8), 5'(i + 2), 32'hA0 + i);
        end
        chk("ovf full", 32'(full), 32'd1);
        chk("ovf level", 32'(level), 32'd4);
        chk("ovf drop", 32'(drop_count), 32'd2);
        for (int i = 0; i < 4; i++) recv($sformatf("ovf rec%0d", i), ov[i]);
        chk("ovf drained", 32'(empty), 32'd1);
        r7 = mk(cyc, 32'h300, 32'h0000_0033, 1'b1, 5'd9, 32'h77);
        wb(32'h300, 32'h0000_0033, 5'd9, 32'h77);
        recv("ovf rec7", r7);

        // Full buffer: push coincides with the final beat handshake.
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr drop", 32'(drop_count), 32'd0);
        chk("clr level", 32'(level), 32'd0);
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f[i] = mk(cyc, 32'h400 + i, 32'h0040_0000 + i, 1'b0, 5'(i + 10), 32'hF0 + i);
            wb(32'h400 + i, 32'h0040_0000 + i, 5'(i + 10), 32'hF0 + i);
        end
        chk("pp full", 32'(full), 32'd1);
        wait_valid("pp");
        rd_ready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            chk($sformatf("pp beat%0d", b), rd_data, f[0][b]);
            if (b == 4) begin
                f4 = mk(cyc, 32'h500, 32'h0050_0000, 1'b0, 5'd20, 32'hBEEF);
                wb_en = 1'b1; wb_tag = 32'h500; wb_instr = 32'h0050_0000;
                wb_rd_addr = 5'd20; wb_data = 32'hBEEF;
            end
            step();
        end
        wb_en = 1'b0;
        chk("pp level", 32'(level), 32'd4);
        chk("pp full2", 32'(full), 32'd1);
        chk("pp drop", 32'(drop_count), 32'd0);
        recv("pp rec1", f[1]);
        recv("pp rec2", f[2]);
        recv("pp rec3", f[3]);
        recv("pp rec4", f4);
        chk("pp empty", 32'(empty), 32'd1);

        // Clear mid-record with a writeback in the same cycle.
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c[i] = mk(cyc, 32'h600 + i, 32'h0060_0000 + i, 1'b0, 5'(i + 1), 32'h60 + i);
            wb(32'h600 + i, 32'h0060_0000 + i, 5'(i + 1), 32'h60 + i);
        end
        chk("cm drop1", 32'(drop_count), 32'd1);
        wait_valid("cm");
        rd_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk($sformatf("cm beat%0d", b), rd_data, c[0][b]);
            step();
        end
        clear = 1'b1;
        wb_en = 1'b1; wb_tag = 32'hDEAD_0000; wb_instr = 32'hDEAD_0001;
        wb_rd_addr = 5'd7; wb_data = 32'hDEAD_0002;
        step();
        clear = 1'b0;
        wb_en = 1'b0;
        chk("cm valid", 32'(rd_valid), 32'd0);
        chk("cm level", 32'(level), 32'd0);
        chk("cm drop", 32'(drop_count), 32'd0);
        chk("cm empty", 32'(empty), 32'd1);
        repeat (3) step();
        chk("cm still idle", 32'(rd_valid), 32'd0);
        chk("cm still empty", 32'(empty), 32'd1);
        nr = mk(cyc, 32'h700, 32'h0070_0000, 1'b0, 5'd4, 32'h70);
        wb(32'h700, 32'h0070_0000, 5'd4, 32'h70);
        recv("cm after", nr);

        // Reset mid-record, then a capture in the first cycle after release.
        wb(32'h800, 32'h0080_0000, 5'd5, 32'h80);
        wait_valid("rm");
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rm valid", 32'(rd_valid), 32'd0);
        chk("rm level", 32'(level), 32'd0);
        chk("rm empty", 32'(empty), 32'd1);
        chk("rm drop", 32'(drop_count), 32'd0);
        chk("rm data", rd_data, 32'd0);
        z = mk(32'd0, 32'h900, 32'h0090_0000, 1'b0, 5'd6, 32'h90);
        wb(32'h900, 32'h0090_0000, 5'd6, 32'h90);
        recv("rm cycle0", z);

        // trace_en=0 ignores writebacks without counting drops; buffered records still drain.
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            t[i] = mk(cyc, 32'hA00 + i, 32'h00A0_0000 + i, 1'b0, 5'(i + 20), 32'hA0A0 + i);
            wb(32'hA00 + i, 32'h00A0_0000 + i, 5'(i + 20), 32'hA0A0 + i);
        end
        trace_en = 1'b0;
        for (int i = 0; i < 3; i++) wb(32'hB00 + i, 32'h00B0_0000, 5'd1, 32'hB0 + i);
        chk("te level", 32'(level), 32'd4);
        chk("te drop", 32'(drop_count), 32'd0);
        for (int i = 0; i < 4; i++) recv($sformatf("te rec%0d", i), t[i]);
        chk("te empty", 32'(empty), 32'd1);
        for (int i = 0; i < 3; i++) wb(32'hC00 + i, 32'h00C0_0000, 5'd2, 32'hC0 + i);
        step();
        step();
        chk("te no rec", 32'(rd_valid), 32'd0);
        chk("te level0", 32'(level), 32'd0);
        chk("te drop0", 32'(drop_count), 32'd0);
        trace_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/commit_trace_buf.md
Name: commit_trace_buf

Overview:
- Hardware-side consumer of the core's writeback stream: exu_wb_rd_wr_en, exu_instr_tag_out, exu_instr_out, exu_wb_rd_addr and exu_wb_data.
- Captures each register-file writeback as a trace record (cycle, tag, instr, rd, data) in an on-chip circular buffer.
- Drains records to a debug/host reader as 32-bit valid/ready beats.
- Sits beside core_top; a bench or debug bridge reads the same trace content without hierarchical probes.

Parameters:
- XLEN, 32, data/tag width. Only 32 is supported; an elaboration-time check fails on any other value.
- DEPTH, 16, number of record entries. Power of 2, >= 2.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- trace_en  in  1  capture enable
- clear  in  1  synchronous flush of buffer and drop counter
- wb_en  in  1  writeback valid, one record per asserted cycle
- wb_tag  in  XLEN  instruction tag/PC
- wb_instr  in  32  instruction word
- wb_rd_addr  in  5  destination register
- wb_data  in  XLEN  written value
- rd_valid  out  1  beat available
- rd_ready  in  1  reader accepts beat
- rd_data  out  32  beat payload
- rd_last  out  1  final beat of a record
- level  out  $clog2(DEPTH)+1  records held
- drop_count  out  DROP_W  records lost to overflow
- full  out  1  level==DEPTH
- empty  out  1  level==0

Behaviour:
- Reset (clk edge with rst_n=0):
  - level=0, empty=1, full=0, drop_count=0
  - rd_valid=0, rd_last=0, rd_data=0
  - cycle counter=0, pending_drop=0, FSM=IDLE
- Cycle counter (32b):
  - Increments every cycle rst_n=1 and wraps at 2^32.
  - Value captured for a record is the counter value in the wb_en cycle; the first cycle after reset release captures 0.
  - Not affected by clear.
- Push:
  - Condition: wb_en & trace_en & !clear & (!full | pop_this_cycle).
  - The record is written to wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Drop:
  - Condition: wb_en & trace_en & !clear & full & !pop_this_cycle.
  - drop_count increments, saturating at all-ones, and pending_drop is set.
  - The next pushed record captures drop_flag=1 and clears pending_drop.
- Record beat order (5 beats):
  - 0: cycle
  - 1: wb_tag
  - 2: wb_instr
  - 3: header {drop_flag, 26'b0, rd_addr}
  - 4: wb_data, with rd_last=1
- Read FSM:
  - States: IDLE and SEND (beat index 0..4).
  - IDLE -> SEND at beat 0 when !empty, registered. rd_valid rises the cycle after the push edge (1-cycle latency).
  - In SEND, the beat index advances only on rd_valid & rd_ready.
  - rd_data and rd_last are held stable while rd_valid & !rd_ready.
  - Handshake on beat 4 is pop_this_cycle: rd_ptr increments and level decrements.
  - After the pop, the FSM goes to beat 0 of the next record if one remains (no bubble); otherwise it goes to IDLE and rd_valid=0.
  - rd_valid never drops mid-record except on clear or reset.
- Simultaneous push and pop: level is unchanged and no drop occurs, including when full.
- level, full and empty are registered and reflect the state after the current edge.
- Clear: next edge gives level=0, pointers=0, drop_count=0, pending_drop=0, FSM=IDLE, rd_valid=0. A record being sent is abandoned mid-record. wb_en during clear is neither stored nor counted.
- trace_en=0: wb_en is ignored with no drop counting; buffered records keep draining.
- Reset mid-record: the same as clear, plus the cycle counter returns to 0.

Decomposition:
- Package trace_pkg:
  - trace_rec_t packed struct {cycle[31:0], tag[XLEN-1:0], instr[31:0], drop_flag, rd_addr[4:0], data[XLEN-1:0]}
  - TRACE_BEATS=5
  - beat index enum BEAT_CYCLE, BEAT_TAG, BEAT_INSTR, BEAT_HDR, BEAT_DATA
  - header bit position constants
- Sub-module trace_fifo: synchronous circular FIFO of trace_rec_t with push, pop, level, full and empty, and same-cycle push+pop when full. The top adds the counters, the drop logic and the serialising FSM.

Test Plan:
- Single record:
  - Stimulus: wb_en at counter 7, tag 0x00000100, instr 0x00500093, rd 1, data 0x5, rd_ready=1.
  - Required response: beats 7, 0x100, 0x00500093, 0x00000001, 0x5 on consecutive cycles; rd_last on beat 5; empty=1 afterwards.
- Backpressure:
  - Stimulus: two back-to-back records, rd_ready toggled 1010...
  - Required response: each beat held stable until accepted; 10 beats in order; no bubble between records when ready.
- Overflow (DEPTH=4, rd_ready=0):
  - Stimulus: 6 writebacks.
  - Required response: full=1, drop_count=2. After draining and pushing a 7th record, its header bit31=1; the earlier 4 records have bit31=0.
- Full with same-cycle push and pop (DEPTH=4):
  - Stimulus: full buffer; wb_en coincides with the beat-4 handshake.
  - Required response: level stays 4, drop_count stays 0, new record read last.
- Clear mid-record:
  - Stimulus: clear after beat 2 accepted, wb_en high that cycle.
  - Required response: next cycle rd_valid=0, level=0, drop_count=0; no record of that wb_en appears later.
- Reset mid-operation and trace_en=0:
  - Stimulus: rst_n=0 for 1 cycle while sending, then trace_en=0 with 3 writebacks.
  - Required response: after reset, rd_valid=0, level=0 and the next captured cycle value is 0. With trace_en=0: no records and drop_count=0.
